// File: rtl/bcd_serial_add_ctrl_if.sv
// Operand/result bundle of the digit-serial BCD adder controller.
// The master supplies operands and a start request; the slave returns the result.
interface bcd_serial_add_ctrl_if #(
  parameter int DIGITS = 4
);
  localparam int W = 4 * DIGITS;

  logic         i_start;
  logic [W-1:0] i_a;
  logic [W-1:0] i_b;
  logic         i_cin;
  logic         o_busy;
  logic         o_done;
  logic [W-1:0] o_sum;
  logic         o_carry;
  logic         o_error;

  modport master (
    output i_start,
    output i_a,
    output i_b,
    output i_cin,
    input  o_busy,
    input  o_done,
    input  o_sum,
    input  o_carry,
    input  o_error
  );

  modport slave (
    input  i_start,
    input  i_a,
    input  i_b,
    input  i_cin,
    output o_busy,
    output o_done,
    output o_sum,
    output o_carry,
    output o_error
  );

endinterface

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder controller.
// One external 4-bit adder is reused for the binary add and the +6 fix-up.
module bcd_serial_add_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  bcd_serial_add_ctrl_if.slave        bus,
  output logic [3:0]                  o_add_a,
  output logic [3:0]                  o_add_b,
  output logic                        o_add_c,
  input  logic [3:0]                  i_add_sum,
  input  logic                        i_add_carry
);

  localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_CORRECT,
    S_DONE
  } state_t;

  typedef logic [DIGITS-1:0][3:0] bcd_t;

  state_t          state_q;
  bcd_t            opa_q;
  bcd_t            opb_q;
  bcd_t            res_q;
  bcd_t            res_d;
  logic [KW-1:0]   k_q;
  logic            c_q;
  logic [3:0]      raw_q;
  logic            rawc_q;
  logic            fix;
  logic            busy_q;
  logic            done_q;
  bcd_t            sum_q;
  logic            carry_q;
  logic            err_q;
  logic            bad_ops;

  function automatic logic has_bad_nibble(input bcd_t v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[i] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // Operand legality check on the live inputs at start time.
  always_comb begin
    bad_ops = has_bad_nibble(bcd_t'(bus.i_a))
            | has_bad_nibble(bcd_t'(bus.i_b));
  end

  // Decimal fix-up is needed when the binary digit sum exceeds 9.
  always_comb begin
    fix = rawc_q | (raw_q > 4'd9);
  end

  // Working result with the current digit replaced by the adder output.
  always_comb begin
    res_d = res_q;
    res_d[k_q] = i_add_sum;
  end

  // Steer the shared adder from the current state.
  always_comb begin
    o_add_a = 4'd0;
    o_add_b = 4'd0;
    o_add_c = 1'b0;
    case (state_q)
      S_ADD: begin
        o_add_a = opa_q[k_q];
        o_add_b = opb_q[k_q];
        o_add_c = c_q;
      end
      S_CORRECT: begin
        o_add_a = raw_q;
        o_add_b = fix ? 4'd6 : 4'd0;
        o_add_c = 1'b0;
      end
      default: begin
        o_add_a = 4'd0;
        o_add_b = 4'd0;
        o_add_c = 1'b0;
      end
    endcase
  end

  // Sequencer: state, working registers and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      k_q     <= '0;
      c_q     <= 1'b0;
      raw_q   <= 4'd0;
      rawc_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.i_start) begin
            opa_q <= bcd_t'(bus.i_a);
            opb_q <= bcd_t'(bus.i_b);
            c_q   <= bus.i_cin;
            k_q   <= '0;
            res_q <= '0;
            err_q <= 1'b0;
            if (bad_ops) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              sum_q   <= '0;
              carry_q <= 1'b0;
              err_q   <= 1'b1;
            end else begin
              state_q <= S_ADD;
              busy_q  <= 1'b1;
            end
          end
        end
        S_ADD: begin
          raw_q   <= i_add_sum;
          rawc_q  <= i_add_carry;
          state_q <= S_CORRECT;
        end
        S_CORRECT: begin
          res_q <= res_d;
          c_q   <= fix;
          if (k_q == K_LAST) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            sum_q   <= res_d;
            carry_q <= fix;
          end else begin
            k_q     <= k_q + KW'(1);
            state_q <= S_ADD;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_busy  = busy_q;
  assign bus.o_done  = done_q;
  assign bus.o_sum   = sum_q;
  assign bus.o_carry = carry_q;
  assign bus.o_error = err_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Bench for bcd_serial_add_ctrl: vector table, corner sequences and
// random operands against a decimal-arithmetic reference model.
module tb_bcd_serial_add_ctrl;

  localparam int D = 4;
  localparam int W = 4 * D;

  logic       clk;
  logic       reset;
  logic [3:0] add_a;
  logic [3:0] add_b;
  logic       add_c;
  logic [3:0] add_sum;
  logic       add_carry;

  int errors;
  int checks;

  bcd_serial_add_ctrl_if #(.DIGITS(D)) bus ();

  bcd_serial_add_ctrl #(.DIGITS(D)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .bus         (bus),
    .o_add_a     (add_a),
    .o_add_b     (add_b),
    .o_add_c     (add_c),
    .i_add_sum   (add_sum),
    .i_add_carry (add_carry)
  );

  // External combinational 4-bit adder.
  assign {add_carry, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_c);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         carry;
    logic         err;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned bcd2int(input logic [W-1:0] v);
    int unsigned r;
    r = 0;
    for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int unsigned n);
    logic [W-1:0] v;
    int unsigned  t;
    t = n;
    v = '0;
    for (int i = 0; i < D; i++) begin
      v[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return v;
  endfunction

  function automatic logic is_bad(input logic [W-1:0] v);
    logic b;
    b = 1'b0;
    for (int i = 0; i < D; i++) if (v[4*i +: 4] > 4'd9) b = 1'b1;
    return b;
  endfunction

  // Number of digits whose decimal column sum (with incoming carry) tops 9.
  function automatic int fix_count(input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   input logic cin);
    int unsigned av, bv, m, lowc, col;
    int          n;
    av = bcd2int(a);
    bv = bcd2int(b);
    n  = 0;
    m  = 1;
    for (int k = 0; k < D; k++) begin
      lowc = ((av % m) + (bv % m) + int'(cin)) / m;
      col  = (av / m) % 10 + (bv / m) % 10 + lowc;
      if (col > 9) n++;
      m = m * 10;
    end
    return n;
  endfunction

  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, output logic [W-1:0] s,
                       output logic c, output logic e);
    int unsigned tot, lim;
    lim = 1;
    for (int i = 0; i < D; i++) lim = lim * 10;
    e = is_bad(a) | is_bad(b);
    if (e) begin
      s = '0;
      c = 1'b0;
    end else begin
      tot = bcd2int(a) + bcd2int(b) + int'(cin);
      s   = int2bcd(tot % lim);
      c   = (tot >= lim);
    end
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic cin,
                        input logic [W-1:0] esum, input logic ecarry,
                        input logic eerr, input bit inj);
    int cyc, busy_n, fix_n, ecyc;
    bit got;
    logic addc0;
    bus.i_a     = a;
    bus.i_b     = b;
    bus.i_cin   = cin;
    bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
    bus.i_a     = W'($urandom);
    bus.i_b     = W'($urandom);
    bus.i_cin   = 1'($urandom);
    cyc    = 1;
    busy_n = 0;
    fix_n  = 0;
    addc0  = 1'b0;
    got    = 0;
    while (!got && cyc <= 40) begin
      if (bus.o_done) begin
        got = 1;
      end else begin
        if (bus.o_busy) busy_n++;
        if (cyc == 1) addc0 = add_c;
        if (cyc % 2 == 0 && bus.o_busy && add_b == 4'd6) fix_n++;
        if (inj && cyc == 3) begin
          bus.i_start = 1'b1;
          bus.i_a     = 16'h1111;
          bus.i_b     = 16'h2222;
        end
        if (inj && cyc == 4) bus.i_start = 1'b0;
        step();
        cyc++;
      end
    end
    ecyc = eerr ? 1 : 2 * D + 1;
    chk({name, " done_seen"}, 32'(got), 32'd1);
    chk({name, " done_cycle"}, 32'(cyc), 32'(ecyc));
    chk({name, " sum"}, 32'(bus.o_sum), 32'(esum));
    chk({name, " carry"}, 32'(bus.o_carry), 32'(ecarry));
    chk({name, " error"}, 32'(bus.o_error), 32'(eerr));
    chk({name, " busy_cycles"}, 32'(busy_n), eerr ? 32'd0 : 32'(2 * D));
    chk({name, " fix_cycles"}, 32'(fix_n),
        eerr ? 32'd0 : 32'(fix_count(a, b, cin)));
    if (!eerr) chk({name, " add_c_digit0"}, 32'(addc0), 32'(cin));
    if (inj) bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
    chk({name, " done_pulse"}, 32'(bus.o_done), 32'd0);
    step();
    chk({name, " idle_after"}, 32'(bus.o_busy), 32'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb, es;
    logic         rc, ec, ee;
    int           cyc;
    bit           seen;

    errors = 0;
    checks = 0;

    tbl[0] = '{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0};
    tbl[1] = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0};
    tbl[3] = '{16'h12A4, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1};
    tbl[4] = '{16'h0000, 16'h000F, 1'b1, 16'h0000, 1'b0, 1'b1};
    tbl[5] = '{16'h4821, 16'h3179, 1'b1, 16'h8001, 1'b0, 1'b0};

    reset       = 1'b1;
    bus.i_start = 1'b0;
    bus.i_a     = '0;
    bus.i_b     = '0;
    bus.i_cin   = 1'b0;
    repeat (3) step();
    reset = 1'b0;

    chk("rst busy", 32'(bus.o_busy), 32'd0);
    chk("rst done", 32'(bus.o_done), 32'd0);
    chk("rst sum", 32'(bus.o_sum), 32'd0);
    chk("rst carry", 32'(bus.o_carry), 32'd0);
    chk("rst error", 32'(bus.o_error), 32'd0);
    chk("rst adder", 32'({add_a, add_b, add_c}), 32'd0);

    for (int i = 0; i < 6; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin,
             tbl[i].sum, tbl[i].carry, tbl[i].err, 1'b0);
    end

    run_op("ignore_start", 16'h0005, 16'h0005, 1'b0,
           16'h0010, 1'b0, 1'b0, 1'b1);
    run_op("after_ignore", 16'h0042, 16'h0058, 1'b0,
           16'h0100, 1'b0, 1'b0, 1'b0);

    bus.i_a     = 16'h0123;
    bus.i_b     = 16'h0456;
    bus.i_cin   = 1'b0;
    bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort busy", 32'(bus.o_busy), 32'd0);
    chk("abort done", 32'(bus.o_done), 32'd0);
    chk("abort sum", 32'(bus.o_sum), 32'd0);
    chk("abort carry", 32'(bus.o_carry), 32'd0);
    chk("abort error", 32'(bus.o_error), 32'd0);
    chk("abort adder", 32'({add_a, add_b, add_c}), 32'd0);
    seen = 0;
    for (cyc = 0; cyc < 12; cyc++) begin
      if (bus.o_done || bus.o_busy) seen = 1;
      step();
    end
    chk("abort no_activity", 32'(seen), 32'd0);
    run_op("post_abort", 16'h0001, 16'h0001, 1'b0,
           16'h0002, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      for (int d = 0; d < D; d++) begin
        ra[4*d +: 4] = 4'($urandom_range(0, 9));
        rb[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 7) == 0)
        ra[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
      rc = 1'($urandom);
      model(ra, rb, rc, es, ec, ee);
      run_op($sformatf("rnd%0d", i), ra, rb, rc, es, ec, ee, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
